// File: rtl/grf.sv
// Architectural register file for the W stage: 31 x 32-bit registers, W->D bypass,
// retirement/write counters and a last-write trace.

module grf_rport (
    input  logic [31:1][31:0] regs,
    input  logic [4:0]        addr,
    input  logic [4:0]        wAddr,
    input  logic [31:0]       wData,
    input  logic              wEn,
    output logic [31:0]       data
);
    always_comb begin
        data = '0;
        if (addr != 5'd0) begin
            // The write in flight wins so D never sees stale data for the register being written.
            if (wEn && addr == wAddr) begin
                data = wData;
            end else begin
                for (int i = 1; i < 32; i++) begin
                    if (addr == 5'(i)) data = regs[i];
                end
            end
        end
    end
endmodule

module grf #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          W_Instr,
    input  logic [31:0]          W_PC,
    input  logic [4:0]           W_RegAddr,
    input  logic [31:0]          W_RegData,
    input  logic                 W_RegWrite,
    input  logic [4:0]           D_RsAddr,
    input  logic [4:0]           D_RtAddr,
    output logic [31:0]          D_RsData,
    output logic [31:0]          D_RtData,
    output logic [CNT_WIDTH-1:0] Retired,
    output logic [CNT_WIDTH-1:0] WriteCnt,
    output logic [31:0]          Last_PC,
    output logic [4:0]           Last_Addr,
    output logic [31:0]          Last_Data
);
    localparam int NUM_PORTS = 2;

    logic [31:1][31:0]                regs;
    logic                             commit;
    logic [NUM_PORTS-1:0][4:0]        rdAddr;
    logic [NUM_PORTS-1:0][31:0]       rdData;

    assign commit = W_RegWrite && (W_RegAddr != 5'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regs <= '0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (commit && W_RegAddr == 5'(i)) regs[i] <= W_RegData;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Retired   <= '0;
            WriteCnt  <= '0;
            Last_PC   <= '0;
            Last_Addr <= '0;
            Last_Data <= '0;
        end else begin
            if (W_Instr != 32'h0) Retired <= Retired + CNT_WIDTH'(1);
            if (commit) begin
                WriteCnt  <= WriteCnt + CNT_WIDTH'(1);
                Last_PC   <= W_PC;
                Last_Addr <= W_RegAddr;
                Last_Data <= W_RegData;
            end
        end
    end

    assign rdAddr = {D_RtAddr, D_RsAddr};

    for (genvar p = 0; p < NUM_PORTS; p++) begin : gRport
        grf_rport uRport (
            .regs  (regs),
            .addr  (rdAddr[p]),
            .wAddr (W_RegAddr),
            .wData (W_RegData),
            .wEn   (W_RegWrite),
            .data  (rdData[p])
        );
    end

    assign D_RsData = rdData[0];
    assign D_RtData = rdData[1];
endmodule

// File: tb/tb_grf.sv
// Directed bench for grf with 4-bit counters: reset, write/read, $0, bypass,
// asynchronous mid-cycle reset and counter wrap.

module tb_grf;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   W_Instr, W_PC, W_RegData;
    logic [4:0]    W_RegAddr, D_RsAddr, D_RtAddr;
    logic          W_RegWrite;
    logic [31:0]   D_RsData, D_RtData;
    logic [CW-1:0] Retired, WriteCnt;
    logic [31:0]   Last_PC, Last_Data;
    logic [4:0]    Last_Addr;

    int tests = 0;
    int fails = 0;

    grf #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset),
        .W_Instr(W_Instr), .W_PC(W_PC), .W_RegAddr(W_RegAddr),
        .W_RegData(W_RegData), .W_RegWrite(W_RegWrite),
        .D_RsAddr(D_RsAddr), .D_RtAddr(D_RtAddr),
        .D_RsData(D_RsData), .D_RtData(D_RtData),
        .Retired(Retired), .WriteCnt(WriteCnt),
        .Last_PC(Last_PC), .Last_Addr(Last_Addr), .Last_Data(Last_Data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        W_Instr = 32'h0; W_PC = 32'h0; W_RegAddr = 5'd0;
        W_RegData = 32'h0; W_RegWrite = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        idle();
        D_RsAddr = 5'd0; D_RtAddr = 5'd0;
        repeat (3) tick();
        chk("rst_retired", 32'(Retired), 32'h0);
        chk("rst_writecnt", 32'(WriteCnt), 32'h0);
        chk("rst_lastpc", Last_PC, 32'h0);
        chk("rst_lastaddr", 32'(Last_Addr), 32'h0);
        chk("rst_lastdata", Last_Data, 32'h0);
        #2 reset = 1'b1;
        tick();
        for (int r = 1; r < 32; r++) begin
            D_RsAddr = 5'(r); D_RtAddr = 5'(r); #1;
            chk($sformatf("rst_rs%0d", r), D_RsData, 32'h0);
            chk($sformatf("rst_rt%0d", r), D_RtData, 32'h0);
        end

        // write $5
        W_Instr = 32'h2345_0001; W_PC = 32'h0000_3000; W_RegAddr = 5'd5;
        W_RegData = 32'h1234_5678; W_RegWrite = 1'b1; D_RsAddr = 5'd5; #1;
        chk("wr5_bypass", D_RsData, 32'h1234_5678);
        tick();
        idle(); #1;
        chk("wr5_read", D_RsData, 32'h1234_5678);
        chk("wr5_lastpc", Last_PC, 32'h0000_3000);
        chk("wr5_lastaddr", 32'(Last_Addr), 32'd5);
        chk("wr5_lastdata", Last_Data, 32'h1234_5678);
        chk("wr5_writecnt", 32'(WriteCnt), 32'd1);
        chk("wr5_retired", 32'(Retired), 32'd1);

        // $0 write is discarded
        W_PC = 32'h0000_3004; W_RegAddr = 5'd0; W_RegData = 32'hFFFF_FFFF; W_RegWrite = 1'b1;
        D_RsAddr = 5'd0; D_RtAddr = 5'd0; #1;
        chk("r0_rs_same", D_RsData, 32'h0);
        chk("r0_rt_same", D_RtData, 32'h0);
        tick();
        idle(); #1;
        chk("r0_rs_after", D_RsData, 32'h0);
        chk("r0_rt_after", D_RtData, 32'h0);
        chk("r0_writecnt", 32'(WriteCnt), 32'd1);
        chk("r0_lastpc", Last_PC, 32'h0000_3000);
        chk("r0_lastaddr", 32'(Last_Addr), 32'd5);

        // bypass: $7 = A, then B in flight
        W_PC = 32'h0000_3008; W_RegAddr = 5'd7; W_RegData = 32'hA; W_RegWrite = 1'b1;
        tick();
        W_PC = 32'h0000_300C; W_RegData = 32'hB; D_RsAddr = 5'd7; D_RtAddr = 5'd7; #1;
        chk("byp_rs", D_RsData, 32'hB);
        chk("byp_rt", D_RtData, 32'hB);
        W_RegAddr = 5'd8; D_RtAddr = 5'd8; #1;
        chk("byp_other_rs7", D_RsData, 32'hA);
        chk("byp_other_rt8", D_RtData, 32'hB);
        tick();
        idle(); #1;
        chk("byp_store_rs7", D_RsData, 32'hA);
        chk("byp_store_rt8", D_RtData, 32'hB);
        chk("byp_writecnt", 32'(WriteCnt), 32'd3);
        chk("byp_lastpc", Last_PC, 32'h0000_300C);

        // asynchronous reset between edges with a write presented
        W_Instr = 32'h1; W_PC = 32'h0000_3010; W_RegAddr = 5'd9; W_RegData = 32'h55;
        W_RegWrite = 1'b1; D_RsAddr = 5'd5; D_RtAddr = 5'd9;
        #2 reset = 1'b0; #1;
        chk("mrst_rs5", D_RsData, 32'h0);
        chk("mrst_rt9_bypass", D_RtData, 32'h55);
        chk("mrst_retired", 32'(Retired), 32'h0);
        chk("mrst_writecnt", 32'(WriteCnt), 32'h0);
        chk("mrst_lastpc", Last_PC, 32'h0);
        chk("mrst_lastaddr", 32'(Last_Addr), 32'h0);
        chk("mrst_lastdata", Last_Data, 32'h0);
        tick();
        idle(); #2 reset = 1'b1; #1;
        chk("mrst_rt9_lost", D_RtData, 32'h0);
        chk("mrst_held_wc", 32'(WriteCnt), 32'h0);

        // counters: 17 non-bubble instrs, 3 commits, then 5 bubbles
        for (int i = 0; i < 22; i++) begin
            idle();
            if (i < 17) W_Instr = 32'(i + 1) | 32'h0040_0000;
            if (i == 2)  begin W_RegWrite = 1'b1; W_RegAddr = 5'd1; W_RegData = 32'h11; W_PC = 32'h4000; end
            if (i == 8)  begin W_RegWrite = 1'b1; W_RegAddr = 5'd2; W_RegData = 32'h22; W_PC = 32'h4004; end
            if (i == 15) begin W_RegWrite = 1'b1; W_RegAddr = 5'd3; W_RegData = 32'h33; W_PC = 32'h4008; end
            tick();
            if (i == 15) chk("cnt_wrap16", 32'(Retired), 32'h0);
        end
        idle(); D_RsAddr = 5'd3; D_RtAddr = 5'd1; #1;
        chk("cnt_retired", 32'(Retired), 32'd1);
        chk("cnt_writecnt", 32'(WriteCnt), 32'd3);
        chk("cnt_rs3", D_RsData, 32'h33);
        chk("cnt_rt1", D_RtData, 32'h11);
        chk("cnt_lastpc", Last_PC, 32'h4008);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
